regfile_mp: RTL and testbench

Parametrised multi-port integer register file with a per-register busy scoreboard. It is the next generation of the single-write, dual-read core register file. Width, register count and port counts are configurable, and write-to-read bypass is optional. A scoreboard tracks in-flight producers so issue logic can detect RAW hazards. It sits between the decode/issue stage (reads, busy checks, destination reservation) and writeback (writes, busy release).

---
 rtl/regfile_mp.sv | 101 ++++++++++
 tb/tb_regfile_mp.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file with a per-register busy scoreboard for RAW hazard detection.
// Register 0 is hardwired to zero; optional same-cycle write-to-read forwarding.
module regfile_mp #(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned NREG   = 32,
   parameter int unsigned NRD    = 2,
   parameter int unsigned NWR    = 1,
   parameter bit          BYPASS = 1'b1,
   localparam int unsigned AW    = $clog2(NREG)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                stall_i,
   input  logic                flush_i,
   input  logic [NWR-1:0]      wr_en_i,
   input  logic [NWR*AW-1:0]   wr_addr_i,
   input  logic [NWR*XLEN-1:0] wr_data_i,
   input  logic [NRD-1:0]      rd_en_i,
   input  logic [NRD*AW-1:0]   rd_addr_i,
   output logic [NRD*XLEN-1:0] rd_data_o,
   output logic [NRD-1:0]      rd_busy_o,
   input  logic                iss_en_i,
   input  logic [AW-1:0]       iss_addr_i,
   output logic                any_busy_o
);

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic [NREG-1:0] busy_q, busy_d;
   logic            any_busy_q;

   logic [AW-1:0]   wa     [NWR];
   logic [XLEN-1:0] wd     [NWR];
   logic [NWR-1:0]  wr_eff;
   logic [AW-1:0]   ra     [NRD];

   for (genvar j = 0; j < NWR; j++) begin : g_wr
      assign wa[j]     = wr_addr_i[j*AW +: AW];
      assign wd[j]     = wr_data_i[j*XLEN +: XLEN];
      assign wr_eff[j] = wr_en_i[j] & ~stall_i & ~rst_i & (wa[j] != '0);
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      assign ra[i] = rd_addr_i[i*AW +: AW];
   end

   // Higher-numbered write ports are applied last so they win collisions.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      for (int j = 0; j < NWR; j++) begin
         if (wr_eff[j]) begin
            regs_d[wa[j]] = wd[j];
            busy_d[wa[j]] = 1'b0;
         end
      end
      if (iss_en_i && !flush_i && (iss_addr_i != '0)) begin
         busy_d[iss_addr_i] = 1'b1;
      end
      if (flush_i) begin
         busy_d = '0;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < NREG; k++) begin
            regs_q[k] <= '0;
         end
         busy_q     <= '0;
         any_busy_q <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         busy_q     <= busy_d;
         any_busy_q <= |busy_d;
      end
   end

   always_comb begin
      rd_data_o = '0;
      rd_busy_o = '0;
      for (int i = 0; i < NRD; i++) begin
         if (!rst_i && rd_en_i[i] && (ra[i] != '0)) begin
            rd_data_o[i*XLEN +: XLEN] = regs_q[ra[i]];
            rd_busy_o[i]              = busy_q[ra[i]];
            if (BYPASS) begin
               for (int j = 0; j < NWR; j++) begin
                  if (wr_eff[j] && (wa[j] == ra[i])) begin
                     rd_data_o[i*XLEN +: XLEN] = wd[j];
                     rd_busy_o[i]              = 1'b0;
                  end
               end
            end
         end
      end
   end

   assign any_busy_o = any_busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (with and without forwarding) share stimulus and are
// compared every cycle against an array-based reference model, plus directed literal checks.
module tb_regfile_mp;

   localparam int XL = 64;
   localparam int AW = 5;

   logic           clk = 1'b0;
   logic           rst, stall, flush, iss_en;
   logic [1:0]     wr_en, rd_en;
   logic [2*AW-1:0] wr_addr, rd_addr;
   logic [2*XL-1:0] wr_data;
   logic [AW-1:0]  iss_addr;
   logic [2*XL-1:0] rd_data_b, rd_data_n;
   logic [1:0]     rd_busy_b, rd_busy_n;
   logic           any_b, any_n;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   logic [XL-1:0] m_regs [32];
   logic [31:0]   m_busy;
   logic          m_any;

   always #5 clk = ~clk;

   regfile_mp #(.XLEN(XL), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1'b1)) dut_b (
      .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b), .rd_busy_o(rd_busy_b),
      .iss_en_i(iss_en), .iss_addr_i(iss_addr), .any_busy_o(any_b)
   );

   regfile_mp #(.XLEN(XL), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1'b0)) dut_n (
      .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data_n), .rd_busy_o(rd_busy_n),
      .iss_en_i(iss_en), .iss_addr_i(iss_addr), .any_busy_o(any_n)
   );

   task automatic chk(input string name, input logic [XL-1:0] act, input logic [XL-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [AW-1:0] wa(input int j);
      return wr_addr[j*AW +: AW];
   endfunction

   function automatic bit weff(input int j);
      return wr_en[j] && !stall && !rst && (wa(j) != 0);
   endfunction

   // Port 1 is searched first: on a collision its data is what a read sees.
   function automatic logic [XL-1:0] exp_data(input bit byp, input int i);
      logic [AW-1:0] a;
      a = rd_addr[i*AW +: AW];
      if (rst || !rd_en[i] || a == 0) return '0;
      if (byp) begin
         for (int j = 1; j >= 0; j--) begin
            if (weff(j) && wa(j) == a) return wr_data[j*XL +: XL];
         end
      end
      return m_regs[a];
   endfunction

   function automatic logic exp_busy(input bit byp, input int i);
      logic [AW-1:0] a;
      a = rd_addr[i*AW +: AW];
      if (rst || !rd_en[i] || a == 0) return 1'b0;
      if (byp && ((weff(0) && wa(0) == a) || (weff(1) && wa(1) == a))) return 1'b0;
      return m_busy[a];
   endfunction

   initial begin
      for (int k = 0; k < 32; k++) m_regs[k] = '0;
      m_busy = '0;
      m_any  = 1'b0;
   end

   // Reference state update.
   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 32; k++) m_regs[k] = '0;
         m_busy = '0;
      end else begin
         for (int j = 0; j < 2; j++) begin
            if (weff(j)) begin
               m_regs[wa(j)] = wr_data[j*XL +: XL];
               m_busy[wa(j)] = 1'b0;
            end
         end
         if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
         if (flush) m_busy = '0;
      end
      m_any = |m_busy;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("cmp_data_b[%0d]", i), rd_data_b[i*XL +: XL], exp_data(1'b1, i));
            chk($sformatf("cmp_data_n[%0d]", i), rd_data_n[i*XL +: XL], exp_data(1'b0, i));
            chk($sformatf("cmp_busy_b[%0d]", i), 64'(rd_busy_b[i]), 64'(exp_busy(1'b1, i)));
            chk($sformatf("cmp_busy_n[%0d]", i), 64'(rd_busy_n[i]), 64'(exp_busy(1'b0, i)));
         end
         chk("cmp_any_b", 64'(any_b), 64'(m_any));
         chk("cmp_any_n", 64'(any_n), 64'(m_any));
      end
   end

   task automatic idle();
      rst = 0; stall = 0; flush = 0; iss_en = 0; iss_addr = '0;
      wr_en = '0; wr_addr = '0; wr_data = '0; rd_en = '0; rd_addr = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int j, input logic [AW-1:0] a, input logic [XL-1:0] d);
      wr_en[j] = 1'b1;
      wr_addr[j*AW +: AW] = a;
      wr_data[j*XL +: XL] = d;
   endtask

   task automatic rd(input int i, input logic [AW-1:0] a);
      rd_en[i] = 1'b1;
      rd_addr[i*AW +: AW] = a;
   endtask

   task automatic iss(input logic [AW-1:0] a);
      iss_en = 1'b1;
      iss_addr = a;
   endtask

   initial begin
      idle();
      rst = 1;
      step();
      idle();
      chk_en = 1'b1;

      // Reset then read
      wr(0, 5, 64'h1234);
      step();
      idle(); rd(0, 5);
      @(negedge clk); chk("x5_written", rd_data_b[63:0], 64'h1234);
      step();
      idle(); rst = 1; rd(0, 5);
      @(negedge clk); chk("rd_during_rst", rd_data_b[63:0], 64'h0);
      step();
      idle(); rd(0, 5);
      @(negedge clk);
      chk("x5_after_rst", rd_data_b[63:0], 64'h0);
      chk("busy_after_rst", 64'(rd_busy_b[0]), 64'h0);
      chk("any_after_rst", 64'(any_b), 64'h0);

      // Bypass vs no bypass
      step();
      idle(); wr(0, 7, 64'hDEAD_BEEF); rd(0, 7);
      @(negedge clk);
      chk("bypass_same_cycle", rd_data_b[63:0], 64'hDEAD_BEEF);
      chk("nobypass_old", rd_data_n[63:0], 64'h0);
      step();
      idle(); rd(0, 7);
      @(negedge clk); chk("nobypass_next", rd_data_n[63:0], 64'hDEAD_BEEF);

      // Write-write collision, port 1 wins
      step();
      idle(); wr(0, 3, 64'h11); wr(1, 3, 64'h22); rd(0, 3);
      @(negedge clk); chk("coll_bypass", rd_data_b[63:0], 64'h22);
      step();
      idle(); rd(0, 3);
      @(negedge clk);
      chk("coll_array_b", rd_data_b[63:0], 64'h22);
      chk("coll_array_n", rd_data_n[63:0], 64'h22);
      step();
      idle(); wr(0, 0, 64'hFFFF); wr(1, 0, 64'h5); rd(1, 0);
      @(negedge clk); chk("x0_bypass", rd_data_b[127:64], 64'h0);
      step();
      idle(); rd(1, 0);
      @(negedge clk); chk("x0_after", rd_data_n[127:64], 64'h0);

      // Scoreboard
      step();
      idle(); iss(9);
      step();
      idle(); rd(0, 9);
      @(negedge clk);
      chk("x9_busy", 64'(rd_busy_b[0]), 64'h1);
      chk("x9_any", 64'(any_b), 64'h1);
      step();
      idle(); rd(0, 9); wr(0, 9, 64'h99); stall = 1;
      @(negedge clk); chk("stall_keeps_busy", 64'(rd_busy_b[0]), 64'h1);
      step();
      idle(); rd(0, 9);
      @(negedge clk); chk("stall_busy_after", 64'(rd_busy_n[0]), 64'h1);
      step();
      idle(); rd(0, 9); wr(0, 9, 64'h99);
      @(negedge clk);
      chk("wb_fwd_busy_b", 64'(rd_busy_b[0]), 64'h0);
      chk("wb_busy_n", 64'(rd_busy_n[0]), 64'h1);
      step();
      idle(); rd(0, 9);
      @(negedge clk);
      chk("wb_cleared", 64'(rd_busy_n[0]), 64'h0);
      chk("wb_any", 64'(any_b), 64'h0);

      // Set and clear in the same cycle: set wins
      step();
      idle(); wr(0, 4, 64'hABCD); iss(4);
      step();
      idle(); rd(0, 4);
      @(negedge clk);
      chk("setclr_data", rd_data_n[63:0], 64'hABCD);
      chk("setclr_busy", 64'(rd_busy_b[0]), 64'h1);

      // Flush with a concurrent issue
      step(); idle(); iss(1);
      step(); idle(); iss(2);
      step(); idle(); iss(31);
      step(); idle(); flush = 1; iss(6);
      step();
      idle(); rd(0, 6); rd(1, 31);
      @(negedge clk);
      chk("flush_busy6", 64'(rd_busy_b[0]), 64'h0);
      chk("flush_busy31", 64'(rd_busy_b[1]), 64'h0);
      chk("flush_any", 64'(any_b), 64'h0);

      // Reset overrides stall, issue and write
      step(); idle(); wr(0, 10, 64'h55); iss(12);
      step(); idle(); rst = 1; stall = 1; wr(1, 11, 64'h66); iss(13); rd(0, 10);
      @(negedge clk); chk("rst_stall_rd", rd_data_b[63:0], 64'h0);
      step();
      idle(); rd(0, 10); rd(1, 11);
      @(negedge clk);
      chk("rst_x10", rd_data_n[63:0], 64'h0);
      chk("rst_x11", rd_data_b[127:64], 64'h0);
      chk("rst_any", 64'(any_n), 64'h0);

      // Randomised traffic against the reference model
      for (int c = 0; c < 3000; c++) begin
         step();
         rst      = ($urandom_range(63) == 0);
         stall    = ($urandom_range(3) == 0);
         flush    = ($urandom_range(31) == 0);
         iss_en   = $urandom_range(1);
         iss_addr = AW'($urandom_range(c[0] ? 31 : 7));
         wr_en    = 2'($urandom);
         rd_en    = 2'($urandom);
         for (int j = 0; j < 2; j++) begin
            wr_addr[j*AW +: AW] = AW'($urandom_range(c[1] ? 31 : 7));
            rd_addr[j*AW +: AW] = AW'($urandom_range(c[1] ? 31 : 7));
            wr_data[j*XL +: XL] = {$urandom, $urandom};
         end
      end
      step();
      idle();
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
